// File: rtl/fence_sequencer.sv
// Fence / fence.i / sfence.vma side-effect sequencer: drain SB, flush DC, IC, TLB in order, redirect fetch.
// Optional DCache-ack watchdog compiled in with FENCE_SEQ_WATCHDOG_EN.
module fence_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fence_i,
  input  logic fence_i_i,
  input  logic sfence_vma_i,
  input  logic sb_empty_i,
  input  logic flush_dcache_ack_i,
  output logic flush_pipeline_o,
  output logic flush_dcache_o,
  output logic flush_icache_o,
  output logic flush_tlb_o,
  output logic set_pc_commit_o,
  output logic halt_o,
  output logic busy_o,
  output logic timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH_DC,
    S_FLUSH_IC,
    S_FLUSH_TLB,
    S_RESUME
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_need_dc, r_need_ic, r_need_tlb, r_flush_pipe;
  logic   w_need_dc_nxt, w_need_ic_nxt, w_need_tlb_nxt, w_flush_pipe_nxt;
  logic   w_req;
  logic   w_dc_done;

  assign w_req = fence_i | fence_i_i | sfence_vma_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_need_dc    <= 1'b0;
      r_need_ic    <= 1'b0;
      r_need_tlb   <= 1'b0;
      r_flush_pipe <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_need_dc    <= w_need_dc_nxt;
      r_need_ic    <= w_need_ic_nxt;
      r_need_tlb   <= w_need_tlb_nxt;
      r_flush_pipe <= w_flush_pipe_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_need_dc_nxt    = r_need_dc;
    w_need_ic_nxt    = r_need_ic;
    w_need_tlb_nxt   = r_need_tlb;
    w_flush_pipe_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Simultaneous requests merge into one sequence via the flag union.
        if (w_req) begin
          w_state_nxt      = S_DRAIN;
          w_need_dc_nxt    = fence_i | fence_i_i;
          w_need_ic_nxt    = fence_i_i;
          w_need_tlb_nxt   = sfence_vma_i;
          w_flush_pipe_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (sb_empty_i) begin
          if (r_need_dc)       w_state_nxt = S_FLUSH_DC;
          else if (r_need_ic)  w_state_nxt = S_FLUSH_IC;
          else if (r_need_tlb) w_state_nxt = S_FLUSH_TLB;
          else                 w_state_nxt = S_RESUME;
        end
      end
      S_FLUSH_DC: begin
        if (w_dc_done) begin
          if (r_need_ic)       w_state_nxt = S_FLUSH_IC;
          else if (r_need_tlb) w_state_nxt = S_FLUSH_TLB;
          else                 w_state_nxt = S_RESUME;
        end
      end
      S_FLUSH_IC:  w_state_nxt = r_need_tlb ? S_FLUSH_TLB : S_RESUME;
      S_FLUSH_TLB: w_state_nxt = S_RESUME;
      S_RESUME: begin
        w_state_nxt    = S_IDLE;
        w_need_dc_nxt  = 1'b0;
        w_need_ic_nxt  = 1'b0;
        w_need_tlb_nxt = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef FENCE_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] r_wd_cnt;
  logic          r_timeout;
  logic          w_wd_expire;

  assign w_wd_expire = (r_state == S_FLUSH_DC) && !flush_dcache_ack_i &&
                       (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero outside FLUSH_DC, so each entry starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_FLUSH_DC) r_wd_cnt <= r_wd_cnt + 1'b1;
      else                       r_wd_cnt <= '0;
      if (w_wd_expire) r_timeout <= 1'b1;
    end
  end

  assign w_dc_done = flush_dcache_ack_i | w_wd_expire;
  assign timeout_o = r_timeout;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_dc_done = flush_dcache_ack_i;
  assign timeout_o = 1'b0;
`endif

  assign flush_pipeline_o = r_flush_pipe;
  assign flush_dcache_o   = (r_state == S_FLUSH_DC);
  assign flush_icache_o   = (r_state == S_FLUSH_IC);
  assign flush_tlb_o      = (r_state == S_FLUSH_TLB);
  assign set_pc_commit_o  = (r_state == S_RESUME);
  assign halt_o           = (r_state != S_IDLE);
  assign busy_o           = (r_state != S_IDLE);

endmodule

// File: doc/fence_sequencer.md
# fence_sequencer

Multi-cycle sequencer for fence, fence.i and sfence.vma side effects: drains the store buffer, flushes DCache, ICache and TLBs in fixed order, then redirects fetch. Sits between the commit stage and the cache/MMU subsystem, alongside the flush controller. While a sequence runs, it halts commit.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: DCache-ack watchdog limit in cycles (≥2). Used only with the watchdog compiled in.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; asynchronous, active-high
- fence_i  in  1  commit of plain fence (single-cycle pulse)
- fence_i_i  in  1  commit of fence.i (pulse)
- sfence_vma_i  in  1  commit of sfence.vma (pulse)
- sb_empty_i  in  1  store buffer holds no committed stores
- flush_dcache_ack_i  in  1  DCache flush complete (pulse)
- flush_pipeline_o  out  1  flush IF/ID/EX and un-issued instructions (pulse)
- flush_dcache_o  out  1  DCache flush request, level, held until ack
- flush_icache_o  out  1  ICache flush (pulse)
- flush_tlb_o  out  1  TLB flush (pulse)
- set_pc_commit_o  out  1  redirect fetch to commit PC + 4 (pulse)
- halt_o  out  1  halt commit stage
- busy_o  out  1  sequence in progress
- timeout_o  out  1  sticky watchdog flag

## Operation
- States: IDLE, DRAIN, FLUSH_DC, FLUSH_IC, FLUSH_TLB, RESUME.
- IDLE: any request high -> capture action flags need_dc = fence_i|fence_i_i, need_ic = fence_i_i, need_tlb = sfence_vma_i; go DRAIN; register flush_pipeline_o = 1 for next cycle only.
- Simultaneous requests merge: union of flags, one sequence.
- Requests outside IDLE are ignored (commit is halted; bench flags them as errors).
- DRAIN: wait until sb_empty_i = 1; then next state = first of FLUSH_DC, FLUSH_IC, FLUSH_TLB whose flag is set, else RESUME.
- FLUSH_DC: flush_dcache_o = 1; stay until flush_dcache_ack_i sampled high, then advance to FLUSH_IC/FLUSH_TLB/RESUME by flags. Ack in any other state is ignored.
- FLUSH_IC: one cycle, flush_icache_o = 1; advance.
- FLUSH_TLB: one cycle, flush_tlb_o = 1; advance.
- RESUME: one cycle, set_pc_commit_o = 1; clear flags; go IDLE.
- halt_o = busy_o = (state != IDLE).
- All outputs are decoded from registered state/flags only. No combinational path from inputs to outputs.

## Timing
- Reset: state IDLE, flags 0, all outputs 0, timeout_o 0, counter 0. Applies at once, including mid-sequence. flush_dcache_o drops asynchronously.
- Request sampled at edge N -> cycle N+1: DRAIN, halt_o = 1, flush_pipeline_o = 1 (this cycle only).
- Minimum plain fence (sb empty, immediate ack): N+1 DRAIN, N+2 FLUSH_DC with ack, N+3 RESUME, N+4 IDLE, halt_o = 0.
- fence.i minimum: DRAIN, FLUSH_DC, FLUSH_IC, RESUME = 4 busy cycles.
- sfence.vma minimum: DRAIN, FLUSH_TLB, RESUME = 3 busy cycles.
- All three merged: DRAIN, FLUSH_DC, FLUSH_IC, FLUSH_TLB, RESUME.
- flush_dcache_o falls in the cycle after the ack is sampled.
- A request in the same cycle as RESUME is ignored. It is accepted only when the state is IDLE.

## Configuration
- FENCE_SEQ_WATCHDOG_EN defined:
  - A cycle counter runs in FLUSH_DC and clears on entry.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack, timeout_o is set and the FSM advances as if acked.
  - timeout_o is sticky until reset.
- Not defined:
  - No counter.
  - FLUSH_DC waits indefinitely.
  - timeout_o tied 0.

## Test plan
- Plain fence, sb_empty_i = 1, ack on first FLUSH_DC cycle -> flush_pipeline_o pulse at N+1, flush_dcache_o high at N+2 only, set_pc_commit_o at N+3, halt_o high N+1..N+3, no icache/tlb pulses.
- fence.i with sb_empty_i low for 5 cycles, ack after 3 FLUSH_DC cycles -> DRAIN lasts 5 cycles, flush_dcache_o held 3 cycles, one flush_icache_o pulse, then one set_pc_commit_o pulse.
- fence, fence.i and sfence.vma asserted in the same cycle -> single sequence: DC, IC and TLB pulses in that order, exactly one set_pc_commit_o.
- sfence.vma while busy with a fence, plus a stray ack in IDLE -> both ignored, no extra flush_tlb_o, state unaffected.
- rst_i asserted during FLUSH_DC -> all outputs 0 immediately. A fence after release runs normally.
- Watchdog enabled, TIMEOUT_CYCLES = 8, no ack -> timeout_o rises after 8 FLUSH_DC cycles, RESUME follows, timeout_o stays 1. Disabled: FSM remains in FLUSH_DC.
